id_ex_pipeline_reg: RTL

ID/EX pipeline register of the five-stage RISC-V core, directly upstream of the EX hazard checker and ALU. It captures decoded instruction fields, register-file read data and control bits from ID each cycle. It holds them when EX requests a stall and converts them to a bubble on a flush. It also refreshes register operands from same-cycle and held-cycle writebacks, so EX never sees a value the register file has already superseded.

---
 rtl/id_ex_pipeline_reg.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX stage register: one-cycle capture of decoded fields, held on EX stall, bubbled on flush or invalid ID.
// Held operands are refreshed from the WB write port so EX never sees stale register data.
module id_ex_pipeline_reg #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ID_valid,
    input  logic [DATA_WIDTH-1:0] ID_pc,
    input  logic [DATA_WIDTH-1:0] ID_imm,
    input  logic [4:0]            ID_rs1,
    input  logic [4:0]            ID_rs2,
    input  logic [4:0]            ID_rd,
    input  logic [DATA_WIDTH-1:0] ID_rs1_data,
    input  logic [DATA_WIDTH-1:0] ID_rs2_data,
    input  logic [6:0]            ID_opcode,
    input  logic [2:0]            ID_funct3,
    input  logic [6:0]            ID_funct7,
    input  logic                  ID_regwrite,
    input  logic                  ID_memread,
    input  logic                  ID_memwrite,
    input  logic                  ID_memtoreg,
    input  logic                  ID_alusrc,
    input  logic                  ID_branch,
    input  logic                  ID_jump,
    input  logic                  WB_regwrite,
    input  logic [4:0]            WB_rd,
    input  logic [DATA_WIDTH-1:0] WB_data,
    input  logic                  EX_stall,
    input  logic                  EX_flush,
    output logic                  ID_EX_valid,
    output logic [DATA_WIDTH-1:0] ID_EX_pc,
    output logic [DATA_WIDTH-1:0] ID_EX_imm,
    output logic [4:0]            ID_EX_rs1,
    output logic [4:0]            ID_EX_rs2,
    output logic [4:0]            ID_EX_rd,
    output logic [DATA_WIDTH-1:0] ID_EX_rs1_data,
    output logic [DATA_WIDTH-1:0] ID_EX_rs2_data,
    output logic [6:0]            ID_EX_opcode,
    output logic [2:0]            ID_EX_funct3,
    output logic [6:0]            ID_EX_funct7,
    output logic                  ID_EX_regwrite,
    output logic                  ID_EX_memread,
    output logic                  ID_EX_memwrite,
    output logic                  ID_EX_memtoreg,
    output logic                  ID_EX_alusrc,
    output logic                  ID_EX_branch,
    output logic                  ID_EX_jump,
    output logic                  ID_hold,
    output logic [15:0]           stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic                  memtoreg;
        logic                  alusrc;
        logic                  branch;
        logic                  jump;
    } stage_t;

    stage_t      stage_q, stage_d, bubble;
    logic [15:0] cnt_q, cnt_d;
    logic        wb_ok;

    // x0 writes never count as a refresh source
    assign wb_ok   = WB_regwrite && (WB_rd != 5'd0);
    assign ID_hold = EX_stall & ~EX_flush;

    always_comb begin
        bubble    = '0;
        bubble.pc = RESET_PC;
    end

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (EX_flush) begin
            stage_d = bubble;
        end else if (EX_stall) begin
            if (wb_ok && (WB_rd == stage_q.rs1)) stage_d.rs1_data = WB_data;
            if (wb_ok && (WB_rd == stage_q.rs2)) stage_d.rs2_data = WB_data;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end else if (!ID_valid) begin
            stage_d = bubble;
        end else begin
            stage_d.valid    = 1'b1;
            stage_d.pc       = ID_pc;
            stage_d.imm      = ID_imm;
            stage_d.rs1      = ID_rs1;
            stage_d.rs2      = ID_rs2;
            stage_d.rd       = ID_rd;
            stage_d.rs1_data = (wb_ok && (WB_rd == ID_rs1)) ? WB_data : ID_rs1_data;
            stage_d.rs2_data = (wb_ok && (WB_rd == ID_rs2)) ? WB_data : ID_rs2_data;
            stage_d.opcode   = ID_opcode;
            stage_d.funct3   = ID_funct3;
            stage_d.funct7   = ID_funct7;
            stage_d.regwrite = ID_regwrite;
            stage_d.memread  = ID_memread;
            stage_d.memwrite = ID_memwrite;
            stage_d.memtoreg = ID_memtoreg;
            stage_d.alusrc   = ID_alusrc;
            stage_d.branch   = ID_branch;
            stage_d.jump     = ID_jump;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q    <= '0;
            stage_q.pc <= RESET_PC;
            cnt_q      <= 16'd0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ID_EX_valid    = stage_q.valid;
    assign ID_EX_pc       = stage_q.pc;
    assign ID_EX_imm      = stage_q.imm;
    assign ID_EX_rs1      = stage_q.rs1;
    assign ID_EX_rs2      = stage_q.rs2;
    assign ID_EX_rd       = stage_q.rd;
    assign ID_EX_rs1_data = stage_q.rs1_data;
    assign ID_EX_rs2_data = stage_q.rs2_data;
    assign ID_EX_opcode   = stage_q.opcode;
    assign ID_EX_funct3   = stage_q.funct3;
    assign ID_EX_funct7   = stage_q.funct7;
    assign ID_EX_regwrite = stage_q.regwrite;
    assign ID_EX_memread  = stage_q.memread;
    assign ID_EX_memwrite = stage_q.memwrite;
    assign ID_EX_memtoreg = stage_q.memtoreg;
    assign ID_EX_alusrc   = stage_q.alusrc;
    assign ID_EX_branch   = stage_q.branch;
    assign ID_EX_jump     = stage_q.jump;
    assign stall_count    = cnt_q;

endmodule
